// File: rtl/loader_pkg.sv
// Shared types and byte-lane constants for the byte stream loader.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/byte_stream_loader_if.sv
// Byte stream input and basic_ram write port bundled together; master is the loader side.
interface byte_stream_loader_if
    import loader_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;
    logic              in_last;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic              ram_cs;
    logic              ram_we;
    logic              ram_oe;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe
    );

endinterface

// File: rtl/word_packer.sv
// Packs bytes big-endian into a word; the first byte of each word clears the low lanes.
module word_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              commit_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_lane_o
);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (push_i) begin
            // Zeroing on lane 0 gives the padding for short final words
            if (idx_q == '0) word_d = '0;
            for (int l = 0; l < BYTES_PER_WORD; l++) begin
                if (idx_q == IDX_W'(l))
                    word_d[(BYTES_PER_WORD-1-l)*BYTE_W +: BYTE_W] = byte_i;
            end
            idx_d = idx_q + IDX_W'(1);
        end else if (commit_i) begin
            idx_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign last_lane_o = (idx_q == IDX_W'(BYTES_PER_WORD-1));

endmodule

// File: rtl/byte_stream_loader.sv
// Loads a byte-stream object image into basic_ram as consecutive big-endian words.
module byte_stream_loader
    import loader_pkg::*;
#(
    parameter int BASE_ADDR = 3000,
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    byte_stream_loader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   word_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;

    logic              start_ok;
    logic              accept;
    logic              word_end;
    logic              last_lane;
    logic [WORD_W-1:0] word;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    assign accept   = (state_q == ST_FILL) && bus.in_valid;
    assign word_end = accept && (last_lane || bus.in_last);

    word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_ok),
        .push_i      (accept),
        .commit_i    (state_q == ST_WRITE),
        .byte_i      (bus.in_data),
        .word_o      (word),
        .last_lane_o (last_lane)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_FILL;
                    count_d = '0;
                    addr_d  = ADDR_W'(BASE_ADDR);
                    last_d  = 1'b0;
                end
            end
            ST_FILL: begin
                if (word_end) begin
                    last_d  = bus.in_last;
                    // Capacity is checked when a word completes, so a full load with no extra word is fine
                    state_d = (count_q == ADDR_W'(MAX_WORDS)) ? ST_ERR : ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_d = count_q + ADDR_W'(1);
                addr_d  = addr_q + ADDR_W'(1);
                state_d = last_q ? ST_DONE : ST_FILL;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_FILL);
    assign bus.ram_cs    = (state_q == ST_WRITE);
    assign bus.ram_we    = (state_q == ST_WRITE);
    assign bus.ram_oe    = 1'b0;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = word;

    assign busy       = (state_q == ST_FILL) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign word_count = count_q;

endmodule

// File: tb/tb_byte_stream_loader.sv
// Directed bench: two loaders (default capacity and MAX_WORDS=2) with a basic_ram write model.
module tb_byte_stream_loader;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [31:0] wc_a, wc_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rdy_viol = 0;
    int wr_cyc_a[$];
    logic [31:0] mem_a[int unsigned];
    logic [31:0] mem_b[int unsigned];

    always #5 clk = ~clk;

    byte_stream_loader_if #(.ADDR_W(32)) bus_a ();
    byte_stream_loader_if #(.ADDR_W(32)) bus_b ();

    byte_stream_loader #(.BASE_ADDR(3000), .ADDR_W(32), .MAX_WORDS(1024)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bus(bus_a.master),
        .busy(busy_a), .done(done_a), .err(err_a), .word_count(wc_a)
    );

    byte_stream_loader #(.BASE_ADDR(3000), .ADDR_W(32), .MAX_WORDS(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bus(bus_b.master),
        .busy(busy_b), .done(done_b), .err(err_b), .word_count(wc_b)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RAM model: a write seen during a cycle commits at the following edge
    initial forever begin
        @(negedge clk);
        if (bus_a.ram_cs && bus_a.ram_we) begin
            mem_a[bus_a.ram_addr] = bus_a.ram_wdata;
            wr_cyc_a.push_back(cyc);
            if (bus_a.in_ready) rdy_viol++;
        end
        if (bus_b.ram_cs && bus_b.ram_we) mem_b[bus_b.ram_addr] = bus_b.ram_wdata;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic l);
        int n = 0;
        if (sel) begin bus_b.in_valid = 1'b1; bus_b.in_data = d; bus_b.in_last = l; end
        else     begin bus_a.in_valid = 1'b1; bus_a.in_data = d; bus_a.in_last = l; end
        while (!(sel ? bus_b.in_ready : bus_a.in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%h ready never seen, waited=%0d want<20", d, n);
        end
        @(negedge clk);
        bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 0; start_b = 0;
        bus_a.in_valid = 0; bus_a.in_data = 0; bus_a.in_last = 0;
        bus_b.in_valid = 0; bus_b.in_data = 0; bus_b.in_last = 0;
        repeat (2) @(negedge clk);
        checks++; if ({bus_a.in_ready, bus_a.ram_cs, bus_a.ram_we, bus_a.ram_oe} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl got=%b want=0000", {bus_a.in_ready, bus_a.ram_cs, bus_a.ram_we, bus_a.ram_oe}); end
        checks++; if (bus_a.ram_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h want=0", bus_a.ram_wdata); end
        checks++; if (bus_a.ram_addr !== 32'd3000) begin errors++; $display("FAIL rst_addr got=%0d want=3000", bus_a.ram_addr); end
        checks++; if ({busy_a, done_a, err_a} !== 3'b000 || wc_a !== 32'd0) begin errors++; $display("FAIL rst_status got=%b wc=%0d want=000 wc=0", {busy_a, done_a, err_a}, wc_a); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy_a, done_a, err_a, bus_a.in_ready} !== 4'b0000) begin errors++; $display("FAIL idle_status got=%b want=0000", {busy_a, done_a, err_a, bus_a.in_ready}); end
    endtask

    task automatic test_basic();
        wr_cyc_a.delete();
        pulse_start(0);
        checks++; if ({busy_a, bus_a.in_ready} !== 2'b11 || wc_a !== 32'd0) begin errors++; $display("FAIL fill_entry got=%b wc=%0d want=11 wc=0", {busy_a, bus_a.in_ready}, wc_a); end
        for (int i = 1; i <= 8; i++) send(0, 8'(i), i == 8);
        checks++; if ({bus_a.ram_cs, bus_a.ram_we, bus_a.in_ready} !== 3'b110) begin errors++; $display("FAIL write_cycle got=%b want=110", {bus_a.ram_cs, bus_a.ram_we, bus_a.in_ready}); end
        checks++; if (bus_a.ram_addr !== 32'd3001 || bus_a.ram_wdata !== 32'h05060708) begin errors++; $display("FAIL write_bus got=%0d/%h want=3001/05060708", bus_a.ram_addr, bus_a.ram_wdata); end
        @(negedge clk);
        checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || wc_a !== 32'd2) begin errors++; $display("FAIL basic_done got=%b%b wc=%0d want=10 wc=2", done_a, busy_a, wc_a); end
        checks++; if (mem_a[3000] !== 32'h01020304) begin errors++; $display("FAIL basic_mem0 got=%h want=01020304", mem_a[3000]); end
        checks++; if (mem_a[3001] !== 32'h05060708) begin errors++; $display("FAIL basic_mem1 got=%h want=05060708", mem_a[3001]); end
        checks++; if (wr_cyc_a.size() != 2 || wr_cyc_a[1] - wr_cyc_a[0] != 5) begin errors++; $display("FAIL basic_spacing got=n%0d d%0d want=n2 d5", wr_cyc_a.size(), (wr_cyc_a.size() == 2) ? wr_cyc_a[1] - wr_cyc_a[0] : -1); end
    endtask

    task automatic test_pad();
        pulse_start(0);
        for (int i = 0; i < 5; i++) send(0, 8'h11 + 8'(i), i == 4);
        checks++; if (bus_a.ram_we !== 1'b1 || bus_a.ram_wdata !== 32'h15000000) begin errors++; $display("FAIL pad_wdata got=%b/%h want=1/15000000", bus_a.ram_we, bus_a.ram_wdata); end
        @(negedge clk);
        checks++; if (done_a !== 1'b1 || wc_a !== 32'd2) begin errors++; $display("FAIL pad_done got=%b wc=%0d want=1 wc=2", done_a, wc_a); end
        checks++; if (mem_a[3000] !== 32'h11121314 || mem_a[3001] !== 32'h15000000) begin errors++; $display("FAIL pad_mem got=%h %h want=11121314 15000000", mem_a[3000], mem_a[3001]); end
    endtask

    task automatic test_back_to_back();
        wr_cyc_a.delete();
        rdy_viol = 0;
        pulse_start(0);
        for (int i = 0; i < 12; i++) send(0, 8'ha0 + 8'(i), i == 11);
        @(negedge clk);
        checks++; if (wr_cyc_a.size() != 3) begin errors++; $display("FAIL b2b_writes got=%0d want=3", wr_cyc_a.size()); end
        else begin
            checks++; if (wr_cyc_a[1] - wr_cyc_a[0] != 5 || wr_cyc_a[2] - wr_cyc_a[1] != 5) begin errors++; $display("FAIL b2b_spacing got=%0d,%0d want=5,5", wr_cyc_a[1] - wr_cyc_a[0], wr_cyc_a[2] - wr_cyc_a[1]); end
        end
        checks++; if (rdy_viol != 0) begin errors++; $display("FAIL b2b_ready_in_write got=%0d want=0", rdy_viol); end
        checks++; if (mem_a[3000] !== 32'ha0a1a2a3 || mem_a[3001] !== 32'ha4a5a6a7 || mem_a[3002] !== 32'ha8a9aaab) begin errors++; $display("FAIL b2b_mem got=%h %h %h want=a0a1a2a3 a4a5a6a7 a8a9aaab", mem_a[3000], mem_a[3001], mem_a[3002]); end
        checks++; if (wc_a !== 32'd3 || done_a !== 1'b1) begin errors++; $display("FAIL b2b_count got=%0d/%b want=3/1", wc_a, done_a); end
    endtask

    task automatic test_rst_mid();
        pulse_start(0);
        for (int i = 0; i < 6; i++) send(0, 8'h21 + 8'(i), 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy_a, done_a, err_a, bus_a.in_ready, bus_a.ram_cs, bus_a.ram_we} !== 6'b0) begin errors++; $display("FAIL rstmid_ctrl got=%b want=000000", {busy_a, done_a, err_a, bus_a.in_ready, bus_a.ram_cs, bus_a.ram_we}); end
        checks++; if (bus_a.ram_addr !== 32'd3000 || wc_a !== 32'd0 || bus_a.ram_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_regs got=%0d wc=%0d wd=%h want=3000 wc=0 wd=0", bus_a.ram_addr, wc_a, bus_a.ram_wdata); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_a[3000] !== 32'h21222324 || mem_a[3001] !== 32'ha4a5a6a7) begin errors++; $display("FAIL rstmid_mem got=%h %h want=21222324 a4a5a6a7", mem_a[3000], mem_a[3001]); end
        pulse_start(0);
        for (int i = 0; i < 4; i++) send(0, 8'h31 + 8'(i), i == 3);
        @(negedge clk);
        checks++; if (mem_a[3000] !== 32'h31323334 || wc_a !== 32'd1 || done_a !== 1'b1) begin errors++; $display("FAIL rstmid_reload got=%h wc=%0d d=%b want=31323334 wc=1 d=1", mem_a[3000], wc_a, done_a); end
    endtask

    task automatic test_restart_done();
        pulse_start(0);
        checks++; if (done_a !== 1'b0 || busy_a !== 1'b1 || wc_a !== 32'd0) begin errors++; $display("FAIL restart_clear got=d%b b%b wc=%0d want=d0 b1 wc=0", done_a, busy_a, wc_a); end
        send(0, 8'h41, 1'b0);
        send(0, 8'h42, 1'b0);
        pulse_start(0);
        send(0, 8'h43, 1'b0);
        send(0, 8'h44, 1'b1);
        @(negedge clk);
        checks++; if (mem_a[3000] !== 32'h41424344 || wc_a !== 32'd1) begin errors++; $display("FAIL restart_mem got=%h wc=%0d want=41424344 wc=1", mem_a[3000], wc_a); end
        checks++; if (done_a !== 1'b1 || bus_a.ram_addr !== 32'd3001) begin errors++; $display("FAIL restart_done got=%b addr=%0d want=1 addr=3001", done_a, bus_a.ram_addr); end
    endtask

    task automatic test_overflow();
        pulse_start(1);
        for (int i = 0; i < 12; i++) send(1, 8'h51 + 8'(i), 1'b0);
        @(negedge clk);
        checks++; if (err_b !== 1'b1 || busy_b !== 1'b0 || bus_b.in_ready !== 1'b0) begin errors++; $display("FAIL ovf_state got=e%b b%b r%b want=e1 b0 r0", err_b, busy_b, bus_b.in_ready); end
        checks++; if (wc_b !== 32'd2) begin errors++; $display("FAIL ovf_count got=%0d want=2", wc_b); end
        checks++; if (mem_b.num() != 2 || mem_b.exists(3002)) begin errors++; $display("FAIL ovf_writes got=%0d want=2 (none at 3002)", mem_b.num()); end
        checks++; if (mem_b[3000] !== 32'h51525354 || mem_b[3001] !== 32'h55565758) begin errors++; $display("FAIL ovf_mem got=%h %h want=51525354 55565758", mem_b[3000], mem_b[3001]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_back_to_back();
        test_rst_mid();
        test_restart_done();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
